// File: rtl/sram_like_responder.sv
// Slave side of the sram-like req/addr_ok/data_ok protocol in front of a one-cycle synchronous RAM.
// Responses return in acceptance order exactly LATENCY cycles after the address handshake.
module sram_like_responder #(
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [MAX_OUTSTANDING-1:0] vld_q, cap_q, wr_q;
  logic [31:0]                dat_q [MAX_OUTSTANDING];
  logic [TW-1:0]              tmr_q [MAX_OUTSTANDING];
  logic [PW-1:0]              head_q, tail_q, pidx_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       pend_q;
  logic                       hs_s, head_rdy_s, size_unused_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign size_unused_s = ^size;

  // addr_ok only looks at the registered count, so a response frees a slot one cycle later.
  assign addr_ok   = ~reset & ~stall & (cnt_q < CW'(MAX_OUTSTANDING));
  assign hs_s      = req & addr_ok;
  assign ram_en    = hs_s;
  assign ram_we    = (hs_s & wr) ? wstrb : 4'h0;
  assign ram_addr  = addr;
  assign ram_wdata = wdata;

  assign head_rdy_s = vld_q[head_q] && (tmr_q[head_q] == TW'(0)) &&
                      ((LATENCY == 1) || cap_q[head_q]);
  assign data_ok    = ~reset & head_rdy_s;

  always_comb begin
    rdata = 32'h0;
    if (data_ok) begin
      if (LATENCY == 1) rdata = wr_q[head_q] ? 32'h0 : ram_rdata;
      else              rdata = dat_q[head_q];
    end else begin
      rdata = 32'h0;
    end
  end

  always_comb begin
    case ({hs_s, data_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      cap_q  <= '0;
      wr_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      pidx_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        dat_q[i] <= 32'h0;
        tmr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (vld_q[i] && (tmr_q[i] != TW'(0))) tmr_q[i] <= tmr_q[i] - TW'(1);
      end
      // RAM data for the entry accepted last cycle arrives now; writes keep their zero.
      if (pend_q) begin
        cap_q[pidx_q] <= 1'b1;
        if (!wr_q[pidx_q]) dat_q[pidx_q] <= ram_rdata;
      end
      if (data_ok) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= next_ptr(head_q);
      end
      if (hs_s) begin
        vld_q[tail_q] <= 1'b1;
        cap_q[tail_q] <= 1'b0;
        wr_q[tail_q]  <= wr;
        dat_q[tail_q] <= 32'h0;
        tmr_q[tail_q] <= TW'(LATENCY - 1);
        tail_q        <= next_ptr(tail_q);
      end
      pend_q <= hs_s;
      pidx_q <= tail_q;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Drives one LATENCY=2 and one LATENCY=1 responder with shared stimulus, each backed by its own RAM,
// and checks both against a queue-based response model every cycle plus directed literal expectations.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset, req, wr, stall;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  logic [1:0]  addr_ok_v, data_ok_v, ram_en_v;
  logic [31:0] rdata_v [2];
  logic [3:0]  ram_we_v [2];
  logic [31:0] ram_addr_v [2];
  logic [31:0] ram_wdata_v [2];
  logic [31:0] ram_rdata_v [2];
  logic [31:0] ram_mem [2][64];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct { int due; logic [31:0] dat; } resp_t;
  resp_t       exp_q [2][$];
  logic [31:0] mdl_mem [2][64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_responder #(.LATENCY(2), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .stall(stall), .addr_ok(addr_ok_v[0]),
    .data_ok(data_ok_v[0]), .rdata(rdata_v[0]), .ram_en(ram_en_v[0]),
    .ram_we(ram_we_v[0]), .ram_addr(ram_addr_v[0]), .ram_wdata(ram_wdata_v[0]),
    .ram_rdata(ram_rdata_v[0]));

  sram_like_responder #(.LATENCY(1), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .stall(stall), .addr_ok(addr_ok_v[1]),
    .data_ok(data_ok_v[1]), .rdata(rdata_v[1]), .ram_en(ram_en_v[1]),
    .ram_we(ram_we_v[1]), .ram_addr(ram_addr_v[1]), .ram_wdata(ram_wdata_v[1]),
    .ram_rdata(ram_rdata_v[1]));

  // Synchronous RAMs: read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_en_v[i]) begin
        ram_rdata_v[i] <= ram_mem[i][ram_addr_v[i][7:2]];
        for (int b = 0; b < 4; b++)
          if (ram_we_v[i][b]) ram_mem[i][ram_addr_v[i][7:2]][b*8 +: 8] <= ram_wdata_v[i][b*8 +: 8];
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, inst, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Reference model: a request accepted at cycle n answers at n+LATENCY with memory contents at n.
  always @(negedge clk) begin : cmp
    logic ea, hs, ed;
    logic [31:0] er, ewe;
    resp_t r;
    for (int i = 0; i < 2; i++) begin
      ea  = !reset && !stall && (exp_q[i].size() < 2);
      hs  = req && ea;
      ed  = !reset && (exp_q[i].size() > 0) && (exp_q[i][0].due == cyc);
      er  = ed ? exp_q[i][0].dat : 32'h0;
      ewe = (hs && wr) ? {28'h0, wstrb} : 32'h0;
      chk("addr_ok", i, {31'h0, addr_ok_v[i]}, {31'h0, ea});
      chk("data_ok", i, {31'h0, data_ok_v[i]}, {31'h0, ed});
      chk("rdata", i, rdata_v[i], er);
      chk("ram_en", i, {31'h0, ram_en_v[i]}, {31'h0, hs});
      chk("ram_we", i, {28'h0, ram_we_v[i]}, ewe);
      if (hs) begin
        chk("ram_addr", i, ram_addr_v[i], addr);
        chk("ram_wdata", i, ram_wdata_v[i], wdata);
      end
      if (reset) begin
        exp_q[i].delete();
      end else begin
        if (ed) void'(exp_q[i].pop_front());
        if (hs) begin
          r.due = cyc + lat_of(i);
          r.dat = wr ? 32'h0 : mdl_mem[i][addr[7:2]];
          exp_q[i].push_back(r);
          if (wr)
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) mdl_mem[i][addr[7:2]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  logic       hs_en;
  logic [3:0] hs_we;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    wr  = 1'b0;
    repeat (n) step();
  endtask

  task automatic at_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  // Presents a request (caller positioned just after a rising edge) until instance 0 accepts it.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int t);
    logic found;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    found = 1'b0;
    t = cyc;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (addr_ok_v[0]) begin
        found = 1'b1;
        t = cyc;
        hs_en = ram_en_v[0];
        hs_we = ram_we_v[0];
      end
      step();
    end
    if (!found) chk("hs_timeout", 0, 32'h0, 32'h1);
  endtask

  initial begin
    int t, ta, tb, tc;
    reset = 1'b1; req = 1'b0; wr = 1'b0; stall = 1'b0; size = 2'd0;
    addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;

    at_cyc(2);
    chk("rst_addr_ok", 0, {31'h0, addr_ok_v[0]}, 32'h0);
    chk("rst_data_ok", 0, {31'h0, data_ok_v[0]}, 32'h0);
    chk("rst_rdata", 0, rdata_v[0], 32'h0);
    chk("rst_ram_en", 0, {31'h0, ram_en_v[0]}, 32'h0);
    chk("rst_ram_we", 0, {28'h0, ram_we_v[0]}, 32'h0);
    step();
    reset = 1'b0;

    issue(1'b1, 32'h1c000000, 4'hf, 32'h02800c0c, t); idle(2);
    issue(1'b1, 32'h1c000004, 4'hf, 32'h13579bdf, t); idle(2);
    issue(1'b1, 32'h1c000008, 4'hf, 32'h2468ace0, t); idle(2);
    issue(1'b1, 32'h1c000010, 4'hf, 32'h11223344, t); idle(4);

    // Single read.
    issue(1'b0, 32'h1c000000, 4'h0, 32'h0, t); idle(0);
    chk("rd_ram_en", 0, {31'h0, hs_en}, 32'h1);
    at_cyc(t + 1);
    chk("rd_dok_t1", 0, {31'h0, data_ok_v[0]}, 32'h0);
    chk("l1_dok_t1", 1, {31'h0, data_ok_v[1]}, 32'h1);
    chk("l1_rdata_t1", 1, rdata_v[1], 32'h02800c0c);
    at_cyc(t + 2);
    chk("rd_dok_t2", 0, {31'h0, data_ok_v[0]}, 32'h1);
    chk("rd_rdata_t2", 0, rdata_v[0], 32'h02800c0c);
    at_cyc(t + 3);
    chk("rd_dok_t3", 0, {31'h0, data_ok_v[0]}, 32'h0);
    step();

    // Back-to-back reads with req held: third one waits for a free slot.
    issue(1'b0, 32'h1c000000, 4'h0, 32'h0, ta);
    issue(1'b0, 32'h1c000004, 4'h0, 32'h0, tb);
    issue(1'b0, 32'h1c000008, 4'h0, 32'h0, tc);
    idle(0);
    chk("b2b_gap1", 0, tb - ta, 32'd1);
    chk("b2b_gap2", 0, tc - ta, 32'd3);
    at_cyc(tc + 1);
    chk("l1_b2b_dok", 1, {31'h0, data_ok_v[1]}, 32'h1);
    chk("l1_b2b_rdata", 1, rdata_v[1], 32'h2468ace0);
    at_cyc(tc + 2);
    chk("b2b_dok3", 0, {31'h0, data_ok_v[0]}, 32'h1);
    chk("b2b_rdata3", 0, rdata_v[0], 32'h2468ace0);
    step();

    // Partial write then read-back.
    issue(1'b1, 32'h1c000010, 4'b0011, 32'haabbccdd, t); idle(0);
    chk("wr_ram_we", 0, {28'h0, hs_we}, 32'h3);
    at_cyc(t + 2);
    chk("wr_dok", 0, {31'h0, data_ok_v[0]}, 32'h1);
    chk("wr_rdata", 0, rdata_v[0], 32'h0);
    step();
    issue(1'b0, 32'h1c000010, 4'h0, 32'h0, t); idle(0);
    at_cyc(t + 2);
    chk("wrrd_dok", 0, {31'h0, data_ok_v[0]}, 32'h1);
    chk("wrrd_rdata", 0, rdata_v[0], 32'h1122ccdd);
    step();

    // Stall holds off the handshake.
    stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h1c000004; wstrb = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_addr_ok", 0, {31'h0, addr_ok_v[0]}, 32'h0);
      chk("stall_ram_en", 0, {31'h0, ram_en_v[0]}, 32'h0);
      chk("stall_ram_en", 1, {31'h0, ram_en_v[1]}, 32'h0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_addr_ok", 0, {31'h0, addr_ok_v[0]}, 32'h1);
    t = cyc;
    step();
    idle(0);
    at_cyc(t + 2);
    chk("unstall_dok", 0, {31'h0, data_ok_v[0]}, 32'h1);
    chk("unstall_rdata", 0, rdata_v[0], 32'h13579bdf);
    step();

    // Reset right after a handshake discards the pending response.
    issue(1'b0, 32'h1c000000, 4'h0, 32'h0, t);
    reset = 1'b1; req = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      at_cyc(t + k);
      chk("rst_drop_dok", 0, {31'h0, data_ok_v[0]}, 32'h0);
      chk("rst_drop_dok", 1, {31'h0, data_ok_v[1]}, 32'h0);
    end
    step();
    issue(1'b0, 32'h1c000000, 4'h0, 32'h0, t); idle(0);
    at_cyc(t + 1);
    chk("post_rst_dok", 1, {31'h0, data_ok_v[1]}, 32'h1);
    chk("post_rst_rdata", 1, rdata_v[1], 32'h02800c0c);
    at_cyc(t + 2);
    chk("post_rst_dok", 0, {31'h0, data_ok_v[0]}, 32'h1);
    chk("post_rst_rdata", 0, rdata_v[0], 32'h02800c0c);
    step();
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
